// File: rtl/reg_writeback_ctrl_if.sv
// Writeback request, regfile write and hazard/forwarding bundle for reg_writeback_ctrl.
// master = producers/read side/regfile, slave = the controller.
interface reg_writeback_ctrl_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          alu_valid;
  logic [AW-1:0] alu_addr;
  logic [DW-1:0] alu_data;
  logic          alu_ready;
  logic          mem_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_ready;
  logic          wr_hold;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          write_reg;
  logic [AW-1:0] rd_addr1;
  logic [AW-1:0] rd_addr2;
  logic          hazard1;
  logic          hazard2;
  logic [DW-1:0] fwd_data1;
  logic [DW-1:0] fwd_data2;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  modport master (
    output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
           wr_hold, rd_addr1, rd_addr2,
    input  alu_ready, mem_ready, wr_addr, wr_data, write_reg,
           hazard1, hazard2, fwd_data1, fwd_data2, count, full, empty
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
           wr_hold, rd_addr1, rd_addr2,
    output alu_ready, mem_ready, wr_addr, wr_data, write_reg,
           hazard1, hazard2, fwd_data1, fwd_data2, count, full, empty
  );
endinterface

// File: rtl/reg_writeback_ctrl.sv
// Two-producer writeback FIFO feeding one registered regfile write per cycle,
// with hazard detection and youngest-wins forwarding over all uncommitted writes.
module reg_writeback_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input logic                clk,
  input logic                rst_n,
  reg_writeback_ctrl_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_t;

  wb_t           fifo_q [DEPTH];
  wb_t           out_q;
  logic          out_vld;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic          alu_rdy, mem_rdy;
  logic          push_alu, push_mem, pop;
  logic [PW-1:0] mem_slot;

  // Readiness looks only at registered occupancy; a pop in the same cycle frees nothing.
  assign alu_rdy  = (count <= CW'(DEPTH-1));
  assign mem_rdy  = bus.alu_valid ? (count <= CW'(DEPTH-2)) : (count <= CW'(DEPTH-1));
  assign push_alu = bus.alu_valid & alu_rdy;
  assign push_mem = bus.mem_valid & mem_rdy;
  assign pop      = (count != '0) & ~bus.wr_hold;
  assign mem_slot = wr_ptr + PW'(push_alu);

  // Storage needs no reset: occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (push_alu) fifo_q[wr_ptr]   <= '{addr: bus.alu_addr, data: bus.alu_data};
    if (push_mem) fifo_q[mem_slot] <= '{addr: bus.mem_addr, data: bus.mem_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      out_q   <= '0;
      out_vld <= 1'b0;
    end else begin
      count   <= count + CW'(push_alu) + CW'(push_mem) - CW'(pop);
      wr_ptr  <= wr_ptr + PW'(push_alu) + PW'(push_mem);
      rd_ptr  <= rd_ptr + PW'(pop);
      out_vld <= pop;
      if (pop) out_q <= fifo_q[rd_ptr];
    end
  end

  // Scan output stage first, then FIFO oldest to youngest so the youngest match wins.
  logic [AW-1:0] rd_addr [2];
  logic          hit     [2];
  logic [DW-1:0] fwd     [2];
  logic [PW-1:0] idx;

  assign rd_addr[0] = bus.rd_addr1;
  assign rd_addr[1] = bus.rd_addr2;

  always_comb begin
    idx = '0;
    for (int p = 0; p < 2; p++) begin
      hit[p] = 1'b0;
      fwd[p] = '0;
      if (out_vld && out_q.addr == rd_addr[p]) begin
        hit[p] = 1'b1;
        fwd[p] = out_q.data;
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = rd_ptr + PW'(i);
        if (CW'(i) < count && fifo_q[idx].addr == rd_addr[p]) begin
          hit[p] = 1'b1;
          fwd[p] = fifo_q[idx].data;
        end
      end
    end
  end

  assign bus.alu_ready = alu_rdy;
  assign bus.mem_ready = mem_rdy;
  assign bus.wr_addr   = out_q.addr;
  assign bus.wr_data   = out_q.data;
  assign bus.write_reg = out_vld;
  assign bus.hazard1   = hit[0];
  assign bus.hazard2   = hit[1];
  assign bus.fwd_data1 = fwd[0];
  assign bus.fwd_data2 = fwd[1];
  assign bus.count     = count;
  assign bus.full      = (count == CW'(DEPTH));
  assign bus.empty     = (count == '0);
endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Scoreboard bench for reg_writeback_ctrl: accepted requests queue expected writes,
// a negedge monitor pops and compares each issued regfile write.
module tb_reg_writeback_ctrl;
  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_writeback_ctrl_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

  reg_writeback_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int mcount = 0;
  logic [AW+DW-1:0] sb [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every issued write must match the oldest outstanding accepted request.
  always @(negedge clk) begin
    if (rst_n && bus.write_reg) begin
      if (sb.size() == 0) chk("spurious_write", 64'd1, 64'd0);
      else begin
        logic [AW+DW-1:0] e;
        e = sb.pop_front();
        chk("wr_addr", 64'(bus.wr_addr), 64'(e[AW+DW-1:DW]));
        chk("wr_data", 64'(bus.wr_data), 64'(e[DW-1:0]));
      end
    end
  end

  // One clock: drive, check ready/occupancy against the model at negedge, update model.
  task automatic cyc(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                     input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                     input logic hold);
    logic er_a, er_m;
    int   pushes, popn;
    bus.alu_valid = av; bus.alu_addr = aa; bus.alu_data = ad;
    bus.mem_valid = mv; bus.mem_addr = ma; bus.mem_data = md;
    bus.wr_hold   = hold;
    @(negedge clk);
    er_a = (mcount <= DEPTH-1);
    er_m = av ? (mcount <= DEPTH-2) : (mcount <= DEPTH-1);
    chk("alu_ready", 64'(bus.alu_ready), 64'(er_a));
    chk("mem_ready", 64'(bus.mem_ready), 64'(er_m));
    chk("count", 64'(bus.count), 64'(mcount));
    chk("full", 64'(bus.full), 64'(mcount == DEPTH));
    chk("empty", 64'(bus.empty), 64'(mcount == 0));
    pushes = 0;
    if (av && er_a) begin sb.push_back({aa, ad}); pushes++; end
    if (mv && er_m) begin sb.push_back({ma, md}); pushes++; end
    popn = (mcount != 0 && !hold) ? 1 : 0;
    mcount = mcount + pushes - popn;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic hold);
    cyc(1'b0, '0, '0, 1'b0, '0, '0, hold);
  endtask

  initial begin
    bus.alu_valid = 0; bus.alu_addr = '0; bus.alu_data = '0;
    bus.mem_valid = 0; bus.mem_addr = '0; bus.mem_data = '0;
    bus.wr_hold = 0; bus.rd_addr1 = '0; bus.rd_addr2 = '0;

    // Reset state
    #2;
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_empty", 64'(bus.empty), 64'd1);
    chk("rst_full", 64'(bus.full), 64'd0);
    chk("rst_write_reg", 64'(bus.write_reg), 64'd0);
    chk("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
    chk("rst_wr_data", 64'(bus.wr_data), 64'd0);
    chk("rst_hazard1", 64'(bus.hazard1), 64'd0);
    chk("rst_fwd1", 64'(bus.fwd_data1), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset mid-traffic discards pending entries
    cyc(1, 5'd1, 32'h101, 0, '0, '0, 1);
    cyc(1, 5'd2, 32'h102, 0, '0, '0, 1);
    cyc(1, 5'd3, 32'h103, 0, '0, '0, 1);
    rst_n = 1'b0;
    #2;
    chk("midrst_count", 64'(bus.count), 64'd0);
    chk("midrst_write_reg", 64'(bus.write_reg), 64'd0);
    sb.delete();
    mcount = 0;
    #1 rst_n = 1'b1;
    repeat (3) idle(0);

    // Single ALU request: latency and hazard window
    bus.rd_addr1 = 5'd5; bus.rd_addr2 = 5'd7;
    cyc(1, 5'd5, 32'h11, 0, '0, '0, 0);
    #1;
    chk("t2_hazard_queued", 64'(bus.hazard1), 64'd1);
    chk("t2_fwd_queued", 64'(bus.fwd_data1), 64'h11);
    chk("t2_wr_not_yet", 64'(bus.write_reg), 64'd0);
    idle(0);
    #1;
    chk("t2_write_reg", 64'(bus.write_reg), 64'd1);
    chk("t2_wr_addr", 64'(bus.wr_addr), 64'd5);
    chk("t2_hazard_out", 64'(bus.hazard1), 64'd1);
    chk("t2_fwd_out", 64'(bus.fwd_data1), 64'h11);
    chk("t6_hazard2_none", 64'(bus.hazard2), 64'd0);
    idle(0);
    #1;
    chk("t2_write_drop", 64'(bus.write_reg), 64'd0);
    chk("t6_hazard1_clear", 64'(bus.hazard1), 64'd0);
    chk("t6_fwd1_clear", 64'(bus.fwd_data1), 64'd0);

    // Dual request to the same address: ALU older, MEM youngest wins
    bus.rd_addr1 = 5'd3; bus.rd_addr2 = 5'd3;
    cyc(1, 5'd3, 32'hA, 1, 5'd3, 32'hB, 0);
    #1;
    chk("t3_fwd1_both", 64'(bus.fwd_data1), 64'hB);
    chk("t3_fwd2_both", 64'(bus.fwd_data2), 64'hB);
    idle(0);
    #1;
    chk("t3_fwd1_fifo_over_out", 64'(bus.fwd_data1), 64'hB);
    idle(0);
    #1;
    chk("t3_fwd1_out", 64'(bus.fwd_data1), 64'hB);
    idle(0);
    #1;
    chk("t3_hazard_clear", 64'(bus.hazard1), 64'd0);

    // Address 0 is forwarded like any other
    bus.rd_addr2 = 5'd0;
    cyc(1, 5'd0, 32'h77, 0, '0, '0, 0);
    #1;
    chk("addr0_hazard2", 64'(bus.hazard2), 64'd1);
    chk("addr0_fwd2", 64'(bus.fwd_data2), 64'h77);
    repeat (2) idle(0);

    // Fill under hold; both valid at Count=DEPTH-1 admits only ALU
    for (int i = 0; i < DEPTH-1; i++) cyc(1, 5'(8+i), 32'h200+i, 0, '0, '0, 1);
    cyc(1, 5'd12, 32'h2F0, 1, 5'd13, 32'h2F1, 1);
    cyc(1, 5'd14, 32'h2F2, 0, '0, '0, 1);
    chk("t4_full", 64'(bus.full), 64'd1);

    // Release hold while pushing; drain across several pointer wraps
    for (int i = 0; i < 5*DEPTH; i++)
      cyc((i % 3) != 0, 5'(i), 32'h5000 + 2*i, (i % 2) != 0, 5'(31-i), 32'h5001 + 2*i, 0);
    for (int k = 0; k < 4*DEPTH && mcount > 0; k++) idle(0);
    repeat (2) idle(0);
    chk("drain_count", 64'(bus.count), 64'd0);
    chk("drain_sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
